// File: rtl/au_seq_pkg.sv
// Shared types for the arithmetic-unit row sequencer: the Aunit control word,
// the sequencer state encoding and default geometry.
package au_seq_pkg;

  localparam int PEROW_DEF = 8;
  localparam int DWD_DEF   = 16;
  localparam int CNTWD_DEF = 8;

  typedef struct packed {
    logic en;
    logic clr;
  } AuCtl;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    CAP  = 2'd2
  } AuSeqState;

  // The first beat of a group loads the product instead of accumulating.
  function automatic AuCtl mk_ctl(input logic beat, input logic first_beat);
    AuCtl ctl;
    ctl.en  = beat;
    ctl.clr = beat & first_beat;
    return ctl;
  endfunction

endpackage

// File: rtl/au_seq_out_buf.sv
// One-entry valid/ready holding register for a finished row of sums.
// A capture may overlap the downstream taking the previous entry.
module au_seq_out_buf
  import au_seq_pkg::*;
#(
  parameter int PEROW = PEROW_DEF,
  parameter int DWD   = DWD_DEF
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_cap,
  input  logic [PEROW-1:0][DWD-1:0]  i_data,
  input  logic                       i_ready,
  output logic                       o_free,
  output logic                       o_valid,
  output logic [PEROW-1:0][DWD-1:0]  o_data
);

  logic                      valid_q;
  logic                      valid_d;
  logic [PEROW-1:0][DWD-1:0] data_q;
  logic [PEROW-1:0][DWD-1:0] data_d;

  assign o_free  = ~valid_q | i_ready;
  assign o_valid = valid_q;
  assign o_data  = data_q;

  // Next-state: capture wins over a concurrent drain.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (i_cap) begin
      valid_d = 1'b1;
      data_d  = i_data;
    end else if (i_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Buffer registers; reset discards any pending result.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/au_seq.sv
// Sequencer for one Aunit MAC row: accepts a job config, drives en/clr per
// input beat and hands each finished group of sums to a one-entry buffer.
module au_seq
  import au_seq_pkg::*;
#(
  parameter int PEROW = PEROW_DEF,
  parameter int DWD   = DWD_DEF,
  parameter int CNTWD = CNTWD_DEF
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_cfg_valid,
  output logic                       o_cfg_ready,
  input  logic [CNTWD-1:0]           i_cfg_len,
  input  logic [CNTWD-1:0]           i_cfg_cnt,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  output AuCtl                       o_ctl,
  input  logic [PEROW-1:0][DWD-1:0]  i_sum,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic [PEROW-1:0][DWD-1:0]  o_out_sum,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_err
);

  AuSeqState        state_q;
  logic [CNTWD-1:0] len_q;
  logic [CNTWD-1:0] cnt_q;
  logic [CNTWD-1:0] beat_q;
  logic [CNTWD-1:0] grp_q;
  logic             cfg_ready_q;
  logic             in_ready_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic cfg_hs;
  logic cfg_bad;
  logic beat;
  logic last_beat;
  logic last_grp;
  logic buf_free;
  logic cap;

  assign cfg_hs    = i_cfg_valid & cfg_ready_q;
  assign cfg_bad   = (i_cfg_len == CNTWD'(0)) | (i_cfg_cnt == CNTWD'(0));
  assign beat      = i_in_valid & in_ready_q;
  assign last_beat = (beat_q == (len_q - CNTWD'(1)));
  assign last_grp  = (grp_q == (cnt_q - CNTWD'(1)));
  assign cap       = (state_q == CAP) & buf_free;

  // en/clr must follow the beat in the same cycle, so only this output is combinational.
  assign o_ctl       = mk_ctl(beat, beat_q == CNTWD'(0));
  assign o_cfg_ready = cfg_ready_q;
  assign o_in_ready  = in_ready_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_err       = err_q;

  // Job FSM with registered handshake/status outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      len_q       <= CNTWD'(0);
      cnt_q       <= CNTWD'(0);
      beat_q      <= CNTWD'(0);
      grp_q       <= CNTWD'(0);
      cfg_ready_q <= 1'b1;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cfg_hs) begin
            len_q  <= i_cfg_len;
            cnt_q  <= i_cfg_cnt;
            beat_q <= CNTWD'(0);
            grp_q  <= CNTWD'(0);
            if (cfg_bad) begin
              err_q <= 1'b1;
            end else begin
              state_q     <= ACC;
              cfg_ready_q <= 1'b0;
              in_ready_q  <= 1'b1;
              busy_q      <= 1'b1;
            end
          end
        end
        ACC: begin
          if (beat) begin
            if (last_beat) begin
              beat_q     <= CNTWD'(0);
              state_q    <= CAP;
              in_ready_q <= 1'b0;
            end else begin
              beat_q <= beat_q + CNTWD'(1);
            end
          end
        end
        CAP: begin
          // Waiting here on a full buffer is what stalls the input stream.
          if (cap) begin
            grp_q <= grp_q + CNTWD'(1);
            if (last_grp) begin
              done_q      <= 1'b1;
              state_q     <= IDLE;
              cfg_ready_q <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              state_q    <= ACC;
              in_ready_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          cfg_ready_q <= 1'b1;
          in_ready_q  <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  au_seq_out_buf #(
    .PEROW (PEROW),
    .DWD   (DWD)
  ) u_out_buf (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_cap   (cap),
    .i_data  (i_sum),
    .i_ready (i_out_ready),
    .o_free  (buf_free),
    .o_valid (o_out_valid),
    .o_data  (o_out_sum)
  );

endmodule

// File: doc/au_seq.md
# au_seq

Sequencer for one arithmetic-unit row (PEROW MAC lanes). It accepts a job configuration (beats per output group and group count) and handshakes the shared input/weight row stream. It drives the Aunit control word (`en`/`clr`) and captures each finished row of sums into a one-entry output buffer with valid/ready backpressure. It sits between the PE-level dataflow controller and the Aunit instance.

## Interface
Parameters:
- PEROW, 8, number of MAC lanes in the row
- DWD, 16, data/sum width per lane
- CNTWD, 8, width of the beat and group counters and their config fields

Ports:
- i_clk  in  1  clock; the only clock
- i_rst  in  1  reset, asynchronous, active-high
- i_cfg_valid  in  1  job config offered
- o_cfg_ready  out  1  config accepted; high only in IDLE
- i_cfg_len  in  CNTWD  MAC beats per output group
- i_cfg_cnt  in  CNTWD  output groups per job
- i_in_valid  in  1  input/weight row beat present; the data goes directly to the Aunit
- o_in_ready  out  1  beat consumed this cycle if i_in_valid
- o_ctl  out  AuCtl  {en, clr} to the Aunit
- i_sum  in  DWD x PEROW  Aunit registered sums
- o_out_valid  out  1  o_out_sum holds a finished group
- i_out_ready  in  1  downstream accepts o_out_sum
- o_out_sum  out  DWD x PEROW  captured group result
- o_busy  out  1  state != IDLE
- o_done  out  1  one-cycle pulse on capture of a job's last group
- o_err  out  1  one-cycle pulse when a config with len==0 or cnt==0 is accepted

## Operation
- Aunit contract:
  - `en & clr`: the lane loads the product.
  - `en & !clr`: the lane accumulates.
  - `!en`: the lane holds.
  - The result is registered, so it is visible on i_sum the cycle after the beat.
- States: IDLE, ACC, CAP.
- IDLE:
  - o_cfg_ready=1.
  - On a config handshake, latch len/cnt and clear beat_cnt and grp_cnt.
  - If len==0 or cnt==0: pulse o_err and stay in IDLE. Otherwise go to ACC.
- ACC:
  - o_in_ready=1. A beat is `i_in_valid & o_in_ready`.
  - o_ctl.en = beat. o_ctl.clr = beat & (beat_cnt==0).
  - On a beat, beat_cnt increments. On a beat with beat_cnt==len-1, beat_cnt is cleared and the state goes to CAP.
  - Cycles with no beat change nothing.
- CAP:
  - o_in_ready=0 and o_ctl=0, so the Aunit holds.
  - Capture i_sum into o_out_sum when the buffer is free: either !o_out_valid, or o_out_valid & i_out_ready in the same cycle.
  - On capture, set o_out_valid and increment grp_cnt.
  - If grp_cnt==cnt-1: pulse o_done and go to IDLE. Otherwise go to ACC.
  - If the buffer is not free, stay in CAP. This stalls the input.
- Output buffer: o_out_valid clears on `i_out_ready` unless a capture occurs in the same cycle. o_out_sum is stable while o_out_valid & !i_out_ready.
- Arithmetic: counters are unsigned CNTWD bits. Sums are passed through unmodified; overflow wraps modulo 2^DWD inside the MAC.
- A new config is accepted only in IDLE. A pending o_out_valid may remain while the next job starts.

## Timing
- Reset values: state IDLE, counters 0, o_cfg_ready=1, o_in_ready=0, o_ctl=0, o_out_valid=0, o_out_sum=0, o_busy=0, o_done=0, o_err=0.
- Reset mid-job discards the job and the buffered result immediately, without waiting for a clock edge.
- Config handshake at cycle t puts the block in ACC at t+1.
- Last beat of a group at cycle t:
  - CAP at t+1, with i_sum valid.
  - Earliest capture at the t+1 edge, so o_out_valid is high at t+2 and ACC resumes at t+2.
- Throughput: len beats per len+1 cycles when unstalled (one bubble per group).
- len==1: every beat has clr=1, and ACC alternates with CAP.
- o_done is coincident with the cycle o_out_valid first rises for the last group.

## Structure
- PECtlCfg package owns:
  - AuCtl typedef {logic en; logic clr;}
  - the state enum AuSeqState {IDLE, ACC, CAP}
- PEROW and DWD come from PECfg.
- No sub-module is needed. A sub-module au_out_buf (the one-entry valid/ready register) is optional.
- The Aunit is instantiated by the parent and wired to o_ctl and i_sum.

## Test plan
All scenarios use PEROW=4, DWD=16 and a behavioural MAC model.
- Reset: assert i_rst mid-cycle -> all outputs at their reset values asynchronously; o_cfg_ready=1.
- len=3, cnt=2, all lanes ipix=2, wpix=3, in_valid always high -> two outputs of 18 on every lane; o_in_ready low exactly one cycle per group; o_done once, with the second o_out_valid.
- len=1, cnt=3, sums 5/6/7, i_out_ready=0 for 6 cycles -> 5 held stable; block stalls in CAP with o_in_ready=0; after release, 5, 6, 7 delivered in order with no loss.
- i_in_valid pattern 1,0,0,1,1 with len=3 -> clr only on the first beat; output captured two cycles after the fifth cycle.
- cfg len=0, cnt=4 -> o_err pulse, o_busy stays 0, o_ctl.en never set; same for len=4, cnt=0.
- i_rst during ACC after 2 of 4 beats -> returns to IDLE with o_out_valid=0; the next job (len=2, cnt=1) gives the correct sum, unaffected by the aborted job.
